// File: rtl/dmem_print_uart_if.sv
// Print-port bundle between the data memory dump logic and the rest of the core.
// master: core/DMem side, slave: the dump engine.
interface dmem_print_uart_if;
    logic       start;
    logic [7:0] print_data;
    logic       print_en;
    logic [3:0] print_addr;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output print_data,
        input  print_en,
        input  print_addr,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  print_data,
        output print_en,
        output print_addr,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/dmem_print_uart.sv
// Dumps DMem bytes 0..NUM_WORDS-1 through the print port as 8N1 UART frames.
// Every output is a register loaded from the current state, so it trails the FSM by one cycle.
module dmem_print_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_WORDS    = 16
) (
    input logic              clk,
    input logic              rst,
    dmem_print_uart_if.slave bus
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      IDX_LAST  = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pe_q, pe_d;
    logic [3:0]    addr_q, addr_d;
    logic          baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pe_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pe_q    <= pe_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                bit_d = '0;
                if (bus.start) state_d = FETCH;
            end
            FETCH: state_d = START;
            START: begin
                // print_addr became valid on the previous edge; capture the byte
                // at the edge that closes the visible print_en cycle.
                if (baud_q == '0) shift_d = bus.print_data;
                baud_d = baud_wrap ? '0 : baud_q + BW'(1);
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                baud_d = baud_wrap ? '0 : baud_q + BW'(1);
                if (baud_wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_wrap ? '0 : baud_q + BW'(1);
                if (baud_wrap) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        pe_d   = 1'b0;
        addr_d = addr_q;
        unique case (state_q)
            FETCH: begin
                pe_d   = 1'b1;
                addr_d = idx_q;
                busy_d = 1'b1;
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_q[0];
                busy_d = 1'b1;
            end
            STOP: busy_d = 1'b1;
            DONE: begin
                done_d = 1'b1;
                addr_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.print_en   = pe_q;
    assign bus.print_addr = addr_q;

endmodule

// File: tb/tb_dmem_print_uart.sv
// Scoreboard bench: one single-word instance timed cycle by cycle, one 16-word
// instance checked by address and UART-decode monitors against queued expectations.
module tb_dmem_print_uart;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst16;
    int   checks = 0;
    int   errors = 0;
    int   done16_cnt = 0;

    logic [7:0] mem16 [16];
    logic [7:0] exp_bytes [$];
    logic [3:0] exp_addrs [$];

    dmem_print_uart_if bus1 ();
    dmem_print_uart_if bus16 ();

    dmem_print_uart #(.CLKS_PER_BIT(CPB), .NUM_WORDS(1)) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    dmem_print_uart #(.CLKS_PER_BIT(CPB), .NUM_WORDS(16)) u16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16.slave)
    );

    assign bus1.print_data  = (bus1.print_addr == 4'd0) ? 8'hA5 : 8'h00;
    assign bus16.print_data = mem16[bus16.print_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx(input int k, input logic [7:0] d);
        if (k >= 2 && k <= 5) return 1'b0;
        if (k >= 6 && k <= 37) return d[(k - 6) / 4];
        return 1'b1;
    endfunction

    // Address scoreboard and done counter for the 16-word instance.
    initial begin : addr_mon
        logic pe_prev;
        pe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst16) begin
                pe_prev = 1'b0;
            end else begin
                if (bus16.print_en) begin
                    chk("print_en_single_cycle", {31'd0, pe_prev}, 32'd0);
                    if (exp_addrs.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL print_addr_unexpected: got addr %0d, want no fetch", bus16.print_addr);
                    end else begin
                        chk("print_addr", {28'd0, bus16.print_addr}, {28'd0, exp_addrs.pop_front()});
                    end
                end
                if (bus16.done) done16_cnt++;
                pe_prev = bus16.print_en;
            end
        end
    end

    // UART decoder: falling edge seen at one negedge, then mid-bit sampling.
    initial begin : uart_mon
        logic       prev_tx;
        logic [7:0] b;
        logic       stop_v;
        logic       abort;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst16 && prev_tx && !bus16.tx) begin
                abort  = 1'b0;
                b      = '0;
                stop_v = 1'b0;
                for (int i = 1; i <= 38; i++) begin
                    @(negedge clk);
                    if (rst16) begin
                        abort = 1'b1;
                        break;
                    end
                    if (i == 2) chk("uart_start_bit", {31'd0, bus16.tx}, 32'd0);
                    if (i >= 6 && i <= 34 && ((i - 6) % 4) == 0) b[(i - 6) / 4] = bus16.tx;
                    if (i == 38) stop_v = bus16.tx;
                end
                if (!abort) begin
                    chk("uart_stop_bit", {31'd0, stop_v}, 32'd1);
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_byte_unexpected: got 0x%0h, want no frame", b);
                    end else begin
                        chk("uart_byte", {24'd0, b}, {24'd0, exp_bytes.pop_front()});
                    end
                end
            end
            prev_tx = bus16.tx;
        end
    end

    task automatic push_run();
        for (int w = 0; w < 16; w++) begin
            exp_bytes.push_back(8'(w * 17));
            exp_addrs.push_back(4'(w));
        end
    endtask

    task automatic check_idle16(input string tag);
        chk({tag, "_tx"},   {31'd0, bus16.tx},         32'd1);
        chk({tag, "_busy"}, {31'd0, bus16.busy},       32'd0);
        chk({tag, "_done"}, {31'd0, bus16.done},       32'd0);
        chk({tag, "_pe"},   {31'd0, bus16.print_en},   32'd0);
        chk({tag, "_addr"}, {28'd0, bus16.print_addr}, 32'd0);
    endtask

    task automatic wait_done16(output int k_done);
        bit seen;
        seen   = 1'b0;
        k_done = 0;
        for (int k = 1; k <= 800 && !seen; k++) begin
            @(negedge clk);
            if (bus16.done) begin
                seen   = 1'b1;
                k_done = k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done16_timeout: got no done in 800 cycles, want one");
        end
    endtask

    task automatic run_dump16(input bit repulse);
        int  busy_n;
        bit  seen;
        push_run();
        done16_cnt = 0;
        busy_n     = 0;
        seen       = 1'b0;
        @(negedge clk); bus16.start = 1'b1;
        @(negedge clk); bus16.start = 1'b0;
        for (int k = 1; k <= 800 && !seen; k++) begin
            @(negedge clk);
            if (repulse && k == 3 * 41 + 10) bus16.start = 1'b1;
            if (repulse && k == 3 * 41 + 11) bus16.start = 1'b0;
            if (repulse && k == 5 * 41 + 10) mem16[5] = 8'h00;
            if (bus16.busy) busy_n++;
            if (bus16.done) begin
                seen = 1'b1;
                chk("done16_cycle", k, 657);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done16_timeout: got no done in 800 cycles, want one");
        end
        chk("busy16_cycles", busy_n, 16 * 41);
        mem16[5] = 8'h55;
        repeat (5) @(negedge clk);
        chk("done16_count", done16_cnt, 1);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("addrs_left", exp_addrs.size(), 0);
    endtask

    initial begin
        int kd;
        int kp;
        bit found;
        rst1 = 1'b1;
        rst16 = 1'b1;
        bus1.start = 1'b0;
        bus16.start = 1'b0;
        for (int i = 0; i < 16; i++) mem16[i] = 8'(i * 17);
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        rst16 = 1'b0;
        repeat (5) @(negedge clk);

        rst1 = 1'b1;
        rst16 = 1'b1;
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        rst16 = 1'b0;
        check_idle16("rst16");
        chk("rst1_tx",   {31'd0, bus1.tx},         32'd1);
        chk("rst1_busy", {31'd0, bus1.busy},       32'd0);
        chk("rst1_done", {31'd0, bus1.done},       32'd0);
        chk("rst1_pe",   {31'd0, bus1.print_en},   32'd0);
        chk("rst1_addr", {28'd0, bus1.print_addr}, 32'd0);

        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            chk("u1_print_en", {31'd0, bus1.print_en}, {31'd0, (k == 1)});
            chk("u1_addr",     {28'd0, bus1.print_addr}, 32'd0);
            chk("u1_tx",       {31'd0, bus1.tx},   {31'd0, exp_tx(k, 8'hA5)});
            chk("u1_busy",     {31'd0, bus1.busy}, {31'd0, (k >= 1 && k <= 41)});
            chk("u1_done",     {31'd0, bus1.done}, {31'd0, (k == 42)});
        end

        run_dump16(1'b0);
        run_dump16(1'b1);

        push_run();
        done16_cnt = 0;
        @(negedge clk); bus16.start = 1'b1;
        @(negedge clk); bus16.start = 1'b0;
        repeat (104) @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        chk("midrst_tx",   {31'd0, bus16.tx},   32'd1);
        chk("midrst_busy", {31'd0, bus16.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus16.done}, 32'd0);
        chk("midrst_pe",   {31'd0, bus16.print_en}, 32'd0);
        chk("midrst_bytes_sent", 32'(exp_bytes.size()), 32'd14);
        exp_bytes.delete();
        exp_addrs.delete();
        repeat (40) @(negedge clk);
        check_idle16("post_rst");
        chk("midrst_done_count", done16_cnt, 0);
        run_dump16(1'b0);

        push_run();
        push_run();
        done16_cnt = 0;
        @(negedge clk); bus16.start = 1'b1;
        wait_done16(kd);
        found = 1'b0;
        kp = 0;
        for (int j = 1; j <= 6 && !found; j++) begin
            @(negedge clk);
            if (bus16.print_en) begin
                found = 1'b1;
                kp = j;
            end
        end
        chk("held_gap", kp, 2);
        bus16.start = 1'b0;
        wait_done16(kd);
        repeat (5) @(negedge clk);
        chk("held_done_count", done16_cnt, 2);
        chk("held_bytes_left", exp_bytes.size(), 0);
        chk("held_addrs_left", exp_addrs.size(), 0);
        check_idle16("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
